// File: rtl/williams_blt_mem_responder.sv
// rtl/williams_blt_mem_responder.sv - blitter bus grant and RAM access responder
// Build option WILLIAMS_BLT_NIBBLE_RMW_EN: partial-nibble writes become read-modify-write on byte-only RAM.
module williams_blt_mem_responder #(
    parameter int ADDR_W        = 16,
    parameter int GRANT_SAMPLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_e_n,
    input  logic              halt,
    output logic              halt_ack,
    output logic              cpu_halt,
    input  logic              cpu_ba,
    input  logic              cpu_bs,
    input  logic              blt_rd,
    input  logic              blt_wr,
    input  logic [ADDR_W-1:0] blt_address,
    input  logic [7:0]        blt_wdata,
    input  logic [1:0]        blt_nibble_en,
    output logic              blt_ack,
    output logic [7:0]        blt_rdata,
    output logic              ram_req,
    output logic              ram_we,
    output logic [1:0]        ram_nwe,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata,
    input  logic              ram_ready
);

    typedef enum logic [2:0] {
        IDLE, GRANT_WAIT, READY, RD, WR, RMW_RD, RMW_WR, ACK
    } state_t;

`ifdef WILLIAMS_BLT_NIBBLE_RMW_EN
    localparam state_t PARTIAL_ST = RMW_RD;
    logic [1:0] nib_q;
`else
    localparam state_t PARTIAL_ST = WR;
`endif

    state_t     state;
    state_t     state_next;
    logic [1:0] grant_cnt;
    logic       halt_lost;
    logic [1:0] nwe_q;
    logic       xfer;
    logic       partial;
    logic       starting;

    assign xfer     = (state == RD) || (state == WR) || (state == RMW_RD) || (state == RMW_WR);
    assign partial  = blt_nibble_en[1] ^ blt_nibble_en[0];
    assign starting = (state == READY) &&
                      ((state_next == RD) || (state_next == WR) || (state_next == RMW_RD));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A RAM cycle already issued always runs to ram_ready; a lost halt only redirects where it ends.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:       if (halt) state_next = GRANT_WAIT;
            GRANT_WAIT: begin
                if (!halt) begin
                    state_next = IDLE;
                end else if (en_e_n && cpu_ba && cpu_bs &&
                             grant_cnt == 2'(GRANT_SAMPLES - 1)) begin
                    state_next = READY;
                end
            end
            READY: begin
                if (!halt) begin
                    state_next = IDLE;
                end else if (blt_rd) begin
                    state_next = RD;
                end else if (blt_wr) begin
                    if (blt_nibble_en == 2'b00) state_next = ACK;
                    else if (partial)           state_next = PARTIAL_ST;
                    else                        state_next = WR;
                end
            end
            RD, WR, RMW_WR: begin
                if (ram_ready) state_next = (halt_lost || !halt) ? IDLE : ACK;
            end
            RMW_RD: begin
                if (ram_ready) state_next = (halt_lost || !halt) ? IDLE : RMW_WR;
            end
            ACK:        if (en_e_n) state_next = READY;
            default:    state_next = IDLE;
        endcase
    end

    always_comb begin
        cpu_halt = (state != IDLE);
        halt_ack = (state != IDLE) && (state != GRANT_WAIT);
        blt_ack  = (state == ACK);
        ram_req  = xfer;
        ram_we   = (state == WR) || (state == RMW_WR);
        ram_nwe  = ram_we ? nwe_q : 2'b00;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt <= 2'd0;
            halt_lost <= 1'b0;
            nwe_q     <= 2'b00;
            blt_rdata <= 8'h00;
            ram_addr  <= '0;
            ram_wdata <= 8'h00;
`ifdef WILLIAMS_BLT_NIBBLE_RMW_EN
            nib_q     <= 2'b00;
`endif
        end else begin
            if (state != GRANT_WAIT) begin
                grant_cnt <= 2'd0;
            end else if (en_e_n) begin
                grant_cnt <= (cpu_ba && cpu_bs) ? grant_cnt + 2'd1 : 2'd0;
            end
            halt_lost <= xfer && (halt_lost || !halt);
            if (starting) begin
                ram_addr  <= blt_address;
                ram_wdata <= blt_wdata;
`ifdef WILLIAMS_BLT_NIBBLE_RMW_EN
                nwe_q     <= 2'b11;
                nib_q     <= blt_nibble_en;
`else
                nwe_q     <= blt_nibble_en;
`endif
            end
            if (state == RD && ram_ready) blt_rdata <= ram_rdata;
`ifdef WILLIAMS_BLT_NIBBLE_RMW_EN
            // Merge: keep the blitter's enabled nibbles, take the rest from the byte just read.
            if (state == RMW_RD && ram_ready) begin
                ram_wdata <= {nib_q[1] ? ram_wdata[7:4] : ram_rdata[7:4],
                              nib_q[0] ? ram_wdata[3:0] : ram_rdata[3:0]};
            end
`endif
        end
    end

endmodule

// File: tb/tb_williams_blt_mem_responder.sv
// tb/tb_williams_blt_mem_responder.sv - scoreboard bench for williams_blt_mem_responder
module tb_williams_blt_mem_responder;

`ifdef WILLIAMS_BLT_NIBBLE_RMW_EN
    localparam int RMW_CYC = 2;
    localparam logic [1:0] MASKED_NWE = 2'b11;
`else
    localparam int RMW_CYC = 1;
    localparam logic [1:0] MASKED_NWE = 2'b10;
`endif
    localparam int GS = 2;

    logic clk, rst, en_e_n, halt, cpu_ba, cpu_bs;
    logic halt_ack, cpu_halt, blt_rd, blt_wr, blt_ack;
    logic [15:0] blt_address, ram_addr;
    logic [7:0] blt_wdata, blt_rdata, ram_wdata, ram_rdata;
    logic [1:0] blt_nibble_en, ram_nwe;
    logic ram_req, ram_we, ram_ready;

    williams_blt_mem_responder #(.ADDR_W(16), .GRANT_SAMPLES(GS)) dut (
        .clk(clk), .rst(rst), .en_e_n(en_e_n), .halt(halt), .halt_ack(halt_ack),
        .cpu_halt(cpu_halt), .cpu_ba(cpu_ba), .cpu_bs(cpu_bs), .blt_rd(blt_rd),
        .blt_wr(blt_wr), .blt_address(blt_address), .blt_wdata(blt_wdata),
        .blt_nibble_en(blt_nibble_en), .blt_ack(blt_ack), .blt_rdata(blt_rdata),
        .ram_req(ram_req), .ram_we(ram_we), .ram_nwe(ram_nwe), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_ready(ram_ready)
    );

    typedef struct {
        bit         is_rd;
        logic [7:0] rdata;
        int         start;
        int         cycles;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] mem[0:65535];
    logic [7:0] ref_mem[0:65535];
    logic [15:0] pool[8];
    int         errors = 0;
    int         checks = 0;
    int         ram_cycles = 0;
    int         ram_lat = -1;
    int         req_violations = 0;
    logic [1:0] last_nwe = 2'b00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        int e_cnt = 0;
        en_e_n = 0;
        forever begin
            @(negedge clk);
            e_cnt  = (e_cnt + 1) % 4;
            en_e_n = (e_cnt == 0);
        end
    end

    // RAM: completes each request after a programmable number of waiting cycles, honours nibble enables.
    initial begin
        int wait_cnt = 0;
        int target = 0;
        ram_ready = 0;
        ram_rdata = 0;
        forever begin
            @(negedge clk);
            ram_ready = 0;
            if (ram_req && !rst) begin
                if (wait_cnt >= target) begin
                    ram_ready = 1;
                    ram_cycles++;
                    if (ram_we) begin
                        if (ram_nwe[1]) mem[ram_addr][7:4] = ram_wdata[7:4];
                        if (ram_nwe[0]) mem[ram_addr][3:0] = ram_wdata[3:0];
                        last_nwe = ram_nwe;
                    end else begin
                        ram_rdata = mem[ram_addr];
                    end
                    wait_cnt = 0;
                    target   = (ram_lat < 0) ? int'($urandom_range(0, 3)) : ram_lat;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
                target   = (ram_lat < 0) ? int'($urandom_range(0, 3)) : ram_lat;
            end
        end
    end

    // Monitor: every acknowledged E sample retires one expected access.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst && blt_ack && en_e_n) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ack", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    if (e.is_rd) check("rdata", blt_rdata, e.rdata);
                    check("ram_cycles", ram_cycles - e.start, e.cycles);
                end
            end
            if (ram_req && !halt_ack) req_violations++;
        end
    end

    task automatic access(input bit rd, input bit wr, input logic [15:0] a,
                          input logic [7:0] d, input logic [1:0] nib);
        exp_t e;
        int n;
        e.is_rd = rd;
        e.start = ram_cycles;
        e.rdata = 8'h00;
        if (rd) begin
            e.rdata  = ref_mem[a];
            e.cycles = 1;
        end else begin
            e.cycles = (nib == 2'b00) ? 0 : ((nib == 2'b11) ? 1 : RMW_CYC);
            if (nib[1]) ref_mem[a][7:4] = d[7:4];
            if (nib[0]) ref_mem[a][3:0] = d[3:0];
        end
        exp_q.push_back(e);
        @(negedge clk);
        blt_rd = rd; blt_wr = wr; blt_address = a; blt_wdata = d; blt_nibble_en = nib;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!(blt_ack && en_e_n) && n < 300);
        if (n >= 300) begin
            check("ack_timeout", 0, 1);
            exp_q.delete();
        end
        blt_rd = 0;
        blt_wr = 0;
        @(negedge clk);
        #1;
        check("ack_drop", blt_ack, 0);
    endtask

    task automatic wait_e();
        int n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!en_e_n && n < 20);
        if (n >= 20) check("e_timeout", 0, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_halt_ack"}, halt_ack, 0);
        check({tag, "_cpu_halt"}, cpu_halt, 0);
        check({tag, "_blt_ack"}, blt_ack, 0);
        check({tag, "_ram_req"}, ram_req, 0);
        check({tag, "_ram_we"}, ram_we, 0);
        check({tag, "_ram_nwe"}, ram_nwe, 0);
        check({tag, "_blt_rdata"}, blt_rdata, 0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] a;
        logic [7:0]  d;
        logic [7:0]  v;
        int          r;
        int          n;
        bit          withdrew;
        bit          acked;

        rst = 1; halt = 0; cpu_ba = 0; cpu_bs = 0;
        blt_rd = 0; blt_wr = 0; blt_address = 0; blt_wdata = 0; blt_nibble_en = 0;
        pool[0] = 16'h1234;
        pool[1] = 16'h2040;
        for (int i = 2; i < 8; i++) pool[i] = 16'($urandom);
        for (int i = 0; i < 8; i++) begin
            v = 8'($urandom);
            mem[pool[i]] = v;
            ref_mem[pool[i]] = v;
        end
        mem[16'h1234] = 8'hA5; ref_mem[16'h1234] = 8'hA5;
        mem[16'h2040] = 8'h31; ref_mem[16'h2040] = 8'h31;

        repeat (3) @(negedge clk);
        rst = 0;
        #1;
        check_all_zero("reset");

        // Grant with BA/BS rising after five E cycles
        @(negedge clk);
        halt = 1;
        @(negedge clk);
        #1;
        check("cpu_halt_immediate", cpu_halt, 1);
        check("halt_ack_early", halt_ack, 0);
        repeat (5) wait_e();
        @(negedge clk);
        cpu_ba = 1; cpu_bs = 1;
        for (int k = 1; k <= GS; k++) begin
            wait_e();
            @(negedge clk);
            #1;
            check($sformatf("halt_ack_after_e%0d", k), halt_ack, (k == GS));
        end

        ram_lat = 3;
        access(1, 0, 16'h1234, 8'h00, 2'b00);
        ram_lat = -1;

        access(0, 1, 16'h2040, 8'h7C, 2'b10);
        check("masked_mem", mem[16'h2040], 8'h71);
        check("masked_nwe", last_nwe, MASKED_NWE);
        access(1, 0, 16'h2040, 8'h00, 2'b00);

        access(0, 1, pool[2], 8'hEE, 2'b00);

        for (int i = 0; i < 40; i++) begin
            a = pool[$urandom_range(0, 7)];
            d = 8'($urandom);
            r = int'($urandom_range(0, 99));
            if (r < 35)      access(1, 0, a, d, 2'($urandom_range(0, 3)));
            else if (r < 45) access(1, 1, a, d, 2'($urandom_range(0, 3)));
            else if (r < 65) access(0, 1, a, d, 2'b11);
            else if (r < 85) access(0, 1, a, d, ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10);
            else             access(0, 1, a, d, 2'b00);
        end

        // Halt drop while a read is pending at the RAM
        ram_lat = 3;
        @(negedge clk);
        blt_rd = 1; blt_address = pool[2];
        n = 0;
        do begin @(negedge clk); #1; n++; end while (!ram_req && n < 50);
        check("drop_req_seen", ram_req, 1);
        @(negedge clk);
        halt = 0;
        withdrew = 0;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
            if (!ram_req) withdrew = 1;
        end while (!ram_ready && n < 50);
        check("drop_req_held", withdrew, 0);
        check("drop_ready_seen", ram_ready, 1);
        @(negedge clk);
        #1;
        blt_rd = 0;
        check("drop_halt_ack", halt_ack, 0);
        check("drop_cpu_halt", cpu_halt, 0);
        check("drop_ram_req", ram_req, 0);
        acked = 0;
        repeat (20) begin @(negedge clk); #1; if (blt_ack) acked = 1; end
        check("drop_no_ack", acked, 0);
        ram_lat = -1;

        halt = 1;
        n = 0;
        do begin @(negedge clk); #1; n++; end while (!halt_ack && n < 100);
        check("regrant_after_drop", halt_ack, 1);

        // Reset during a write that the RAM never completes
        ram_lat = 1000;
        @(negedge clk);
        blt_wr = 1; blt_nibble_en = 2'b11; blt_address = pool[3]; blt_wdata = 8'h5A;
        n = 0;
        do begin @(negedge clk); #1; n++; end while (!(ram_req && ram_we) && n < 50);
        check("rst_wr_started", ram_req && ram_we, 1);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        #1;
        check_all_zero("midwr_reset");
        rst = 0;
        blt_wr = 0;
        ram_lat = -1;
        n = 0;
        do begin @(negedge clk); #1; n++; end while (!halt_ack && n < 100);
        check("regrant_after_reset", halt_ack, 1);
        access(1, 0, pool[3], 8'h00, 2'b00);

        repeat (4) @(negedge clk);
        for (int i = 0; i < 8; i++) check($sformatf("mem_%0d", i), mem[pool[i]], ref_mem[pool[i]]);
        check("queue_drained", exp_q.size(), 0);
        check("ram_req_without_grant", req_violations, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
